if_id_buffer: RTL and testbench

- Sits between fetch and decode; carries instruction and PC_next from fetch to decode.
- Provides a small instruction FIFO (skid buffer) so decode stalls do not lose fetched words.
- Handles branch flush.
- Serialises interrupt entry: drains the buffer, injects INT_INST into decode, then returns ACK to the interrupt source.

---
 rtl/if_id_buffer_if.sv | 25 ++
 rtl/if_id_buffer.sv | 110 +++++++++++
 tb/tb_if_id_buffer.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/if_id_buffer_if.sv
// Fetch/decode pipeline bus around the IF/ID skid buffer.
// slave = buffer side, master = fetch/decode environment side.
interface if_id_buffer_if #(
  parameter int unsigned WIDTH = 32
);
  logic             in_valid;
  logic [WIDTH-1:0] in_instr;
  logic [WIDTH-1:0] in_PC_next;
  logic             in_ready;
  logic             stall;
  logic             out_valid;
  logic [WIDTH-1:0] out_instr;
  logic [WIDTH-1:0] out_PC_next;
  logic             out_int;

  modport slave (
    input  in_valid, in_instr, in_PC_next, stall,
    output in_ready, out_valid, out_instr, out_PC_next, out_int
  );

  modport master (
    output in_valid, in_instr, in_PC_next, stall,
    input  in_ready, out_valid, out_instr, out_PC_next, out_int
  );
endinterface

// File: rtl/if_id_buffer.sv
// IF/ID skid FIFO with branch flush and serialised interrupt injection
// (drain buffer, present INT_INST to decode, ACK when consumed).
module if_id_buffer #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned WIDTH = 32
) (
  input  logic                         clk,
  input  logic                         rst,
  if_id_buffer_if.slave                bus,
  input  logic                         flush,
  input  logic                         INT,
  input  logic [WIDTH-1:0]             INT_INST,
  output logic                         ACK,
  output logic [$clog2(DEPTH+1)-1:0]   count
);
  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH+1);

  typedef enum logic [1:0] {IDLE, DRAIN, INJECT, WAITLOW} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] instr_mem [DEPTH];
  logic [WIDTH-1:0] pc_mem    [DEPTH];
  logic [PW-1:0]    wr_ptr, rd_ptr;
  logic [CW-1:0]    count_nxt;
  logic [WIDTH-1:0] last_pc;
  logic             buf_valid, push, buf_pop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH-1)) ? '0 : p + PW'(1);
  endfunction

  // Buffered entries are only visible outside INJECT/WAITLOW; count is 0 there anyway.
  assign buf_valid    = (count != '0) && (state == IDLE || state == DRAIN);
  assign bus.in_ready = (count != CW'(DEPTH)) && (state == IDLE);
  assign push         = bus.in_valid & bus.in_ready & ~flush;
  assign buf_pop      = buf_valid & ~bus.stall;

  always_comb begin
    bus.out_valid   = 1'b0;
    bus.out_instr   = '0;
    bus.out_PC_next = '0;
    bus.out_int     = 1'b0;
    if (state == INJECT) begin
      bus.out_valid   = 1'b1;
      bus.out_instr   = INT_INST;
      bus.out_PC_next = last_pc;
      bus.out_int     = 1'b1;
    end else if (buf_valid) begin
      bus.out_valid   = 1'b1;
      bus.out_instr   = instr_mem[rd_ptr];
      bus.out_PC_next = pc_mem[rd_ptr];
    end
  end

  assign ACK = (state == INJECT) & ~bus.stall & ~rst;

  always_comb begin
    count_nxt = count;
    if (flush) begin
      count_nxt = '0;
    end else begin
      case ({push, buf_pop})
        2'b10:   count_nxt = count + CW'(1);
        2'b01:   count_nxt = count - CW'(1);
        default: count_nxt = count;
      endcase
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (INT) state_nxt = DRAIN;
      DRAIN:   if (count_nxt == '0) state_nxt = INJECT;
      INJECT:  if (!bus.stall) state_nxt = WAITLOW;
      WAITLOW: if (!INT) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      count   <= '0;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      last_pc <= '0;
    end else begin
      state <= state_nxt;
      count <= count_nxt;
      if (flush) begin
        rd_ptr <= wr_ptr;
      end else begin
        if (push) wr_ptr <= ptr_inc(wr_ptr);
        if (buf_pop) begin
          rd_ptr  <= ptr_inc(rd_ptr);
          last_pc <= pc_mem[rd_ptr];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      instr_mem[wr_ptr] <= bus.in_instr;
      pc_mem[wr_ptr]    <= bus.in_PC_next;
    end
  end
endmodule

// File: tb/tb_if_id_buffer.sv
// Bench for if_id_buffer: directed vector table, interrupt sequences and a
// random run compared against a queue-based reference model.
module tb_if_id_buffer;
  localparam int unsigned DEPTH = 2;
  localparam int unsigned WIDTH = 32;

  logic             clk = 1'b0;
  logic             rst;
  logic             flush;
  logic             INT;
  logic [WIDTH-1:0] INT_INST;
  logic             ACK;
  logic [1:0]       count;

  if_id_buffer_if #(.WIDTH(WIDTH)) bus ();

  if_id_buffer #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
    .clk(clk), .rst(rst), .bus(bus), .flush(flush), .INT(INT),
    .INT_INST(INT_INST), .ACK(ACK), .count(count)
  );

  always #5 clk = ~clk;

  int passed = 0;
  int total  = 0;

  typedef struct { logic [31:0] instr; logic [31:0] pc; } ent_t;
  ent_t        q[$];
  bit          draining, inj, wait_low;
  logic [31:0] last_pc;

  typedef struct {
    logic        v; logic [31:0] instr; logic [31:0] pc; logic stall; logic flush;
    logic        e_valid; logic [31:0] e_instr; logic [31:0] e_count; logic e_ready;
  } vec_t;
  vec_t vecs[15];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Compare every output against the model, advance the model, move to next negedge.
  task automatic cycle(input string tag);
    logic ev, er, ea, eint;
    logic [31:0] ei, ep;
    bit do_pop, do_push;
    #2;
    ev   = inj ? 1'b1 : (wait_low ? 1'b0 : (q.size() != 0));
    eint = inj;
    ei   = inj ? INT_INST : ((ev) ? q[0].instr : 32'h0);
    ep   = inj ? last_pc  : ((ev) ? q[0].pc    : 32'h0);
    er   = !draining && !inj && !wait_low && (q.size() < DEPTH);
    ea   = inj && !bus.stall && !rst;
    chk({tag, ".out_valid"},   32'(bus.out_valid), 32'(ev));
    chk({tag, ".out_instr"},   bus.out_instr, ei);
    chk({tag, ".out_PC_next"}, bus.out_PC_next, ep);
    chk({tag, ".out_int"},     32'(bus.out_int), 32'(eint));
    chk({tag, ".in_ready"},    32'(bus.in_ready), 32'(er));
    chk({tag, ".ACK"},         32'(ACK), 32'(ea));
    chk({tag, ".count"},       32'(count), 32'(q.size()));
    if (rst) begin
      q.delete(); draining = 0; inj = 0; wait_low = 0; last_pc = '0;
    end else begin
      do_pop  = ev && !bus.stall;
      do_push = bus.in_valid && er && !flush;
      if (inj) begin
        if (do_pop) begin inj = 0; wait_low = 1; end
      end else if (wait_low) begin
        if (!INT) wait_low = 0;
      end else begin
        if (flush) q.delete();
        else begin
          if (do_pop) begin last_pc = q[0].pc; void'(q.pop_front()); end
          if (do_push) q.push_back('{bus.in_instr, bus.in_PC_next});
        end
        if (draining) begin
          if (q.size() == 0) begin draining = 0; inj = 1; end
        end else if (INT) draining = 1;
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drive(input logic v, input logic [31:0] i, input logic [31:0] p,
                       input logic st, input logic fl);
    bus.in_valid = v; bus.in_instr = i; bus.in_PC_next = p; bus.stall = st; flush = fl;
  endtask

  initial begin
    rst = 1'b1; INT = 1'b0; INT_INST = '0;
    drive(1'b0, '0, '0, 1'b0, 1'b0);
    q.delete(); draining = 0; inj = 0; wait_low = 0; last_pc = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    // v instr pc stall flush | valid instr count ready  (outputs before the edge)
    vecs[0]  = '{0, 32'h0, 32'h0,   0, 0, 0, 32'h0, 0, 1};
    vecs[1]  = '{1, 32'hA, 32'h4,   0, 0, 0, 32'h0, 0, 1};
    vecs[2]  = '{1, 32'hB, 32'h8,   0, 0, 1, 32'hA, 1, 1};
    vecs[3]  = '{0, 32'h0, 32'h0,   0, 0, 1, 32'hB, 1, 1};
    vecs[4]  = '{0, 32'h0, 32'h0,   0, 0, 0, 32'h0, 0, 1};
    vecs[5]  = '{1, 32'h1, 32'h10,  1, 0, 0, 32'h0, 0, 1};
    vecs[6]  = '{1, 32'h2, 32'h14,  1, 0, 1, 32'h1, 1, 1};
    vecs[7]  = '{1, 32'h3, 32'h18,  1, 0, 1, 32'h1, 2, 0};
    vecs[8]  = '{0, 32'h0, 32'h0,   0, 0, 1, 32'h1, 2, 0};
    vecs[9]  = '{0, 32'h0, 32'h0,   0, 0, 1, 32'h2, 1, 1};
    vecs[10] = '{0, 32'h0, 32'h0,   0, 0, 0, 32'h0, 0, 1};
    vecs[11] = '{1, 32'h5, 32'h20,  1, 0, 0, 32'h0, 0, 1};
    vecs[12] = '{1, 32'h6, 32'h24,  1, 0, 1, 32'h5, 1, 1};
    vecs[13] = '{1, 32'h7, 32'h28,  1, 1, 1, 32'h5, 2, 0};
    vecs[14] = '{0, 32'h0, 32'h0,   0, 0, 0, 32'h0, 0, 1};
    for (int i = 0; i < 15; i++) begin
      drive(vecs[i].v, vecs[i].instr, vecs[i].pc, vecs[i].stall, vecs[i].flush);
      #1;
      chk($sformatf("vec%0d.valid", i), 32'(bus.out_valid), 32'(vecs[i].e_valid));
      chk($sformatf("vec%0d.instr", i), bus.out_instr, vecs[i].e_instr);
      chk($sformatf("vec%0d.count", i), 32'(count), vecs[i].e_count);
      chk($sformatf("vec%0d.ready", i), 32'(bus.in_ready), 32'(vecs[i].e_ready));
      cycle("vec");
    end

    // Interrupt while one entry (PC 0x104) is buffered.
    drive(1, 32'h11, 32'h100, 0, 0); cycle("int_a");
    drive(1, 32'h12, 32'h104, 0, 0);
    #1 chk("int_pop_pc", bus.out_PC_next, 32'h100); cycle("int_b");
    drive(0, 0, 0, 1, 0); INT = 1; INT_INST = 32'hDEAD;
    #1 chk("int_head", bus.out_instr, 32'h12); cycle("int_c");
    drive(0, 0, 0, 0, 0);
    #1 chk("drain_ready", 32'(bus.in_ready), 32'h0); cycle("int_d");
    #1 chk("inj_instr", bus.out_instr, 32'hDEAD);
    chk("inj_int", 32'(bus.out_int), 32'h1);
    chk("inj_pc", bus.out_PC_next, 32'h104);
    chk("inj_ack", 32'(ACK), 32'h1); cycle("int_e");
    drive(1, 32'h99, 32'h0, 0, 0);
    #1 chk("wl_ack", 32'(ACK), 32'h0);
    chk("wl_ready", 32'(bus.in_ready), 32'h0);
    chk("wl_valid", 32'(bus.out_valid), 32'h0); cycle("int_f");
    drive(0, 0, 0, 0, 0); INT = 0;
    #1 chk("wl_ready2", 32'(bus.in_ready), 32'h0); cycle("int_g");
    #1 chk("idle_ready", 32'(bus.in_ready), 32'h1); cycle("int_h");

    // Injection held by stall with flush asserted.
    INT = 1; INT_INST = 32'hBEEF; drive(0, 0, 0, 1, 0);
    cycle("hold_a"); cycle("hold_b");
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 0, 1, 1);
      #1 chk($sformatf("hold%0d.instr", i), bus.out_instr, 32'hBEEF);
      chk($sformatf("hold%0d.int", i), 32'(bus.out_int), 32'h1);
      chk($sformatf("hold%0d.ack", i), 32'(ACK), 32'h0);
      cycle("hold");
    end
    drive(0, 0, 0, 0, 0);
    #1 chk("hold_release_ack", 32'(ACK), 32'h1); cycle("hold_c");
    #1 chk("hold_ack_once", 32'(ACK), 32'h0); INT = 0; cycle("hold_d");
    cycle("hold_e");

    // Reset during INJECT abandons the interrupt.
    INT = 1; INT_INST = 32'hCAFE; drive(0, 0, 0, 1, 0);
    cycle("rst_a"); cycle("rst_b");
    #1 chk("rst_pre_int", 32'(bus.out_int), 32'h1);
    rst = 1; INT = 0; bus.stall = 0;
    #1 chk("rst_ack", 32'(ACK), 32'h0); cycle("rst_c");
    rst = 0;
    #1 chk("rst_valid", 32'(bus.out_valid), 32'h0);
    chk("rst_count", 32'(count), 32'h0);
    chk("rst_int", 32'(bus.out_int), 32'h0);
    chk("rst_ack2", 32'(ACK), 32'h0);
    repeat (3) cycle("rst_after");

    // Random run against the model.
    for (int n = 0; n < 600; n++) begin
      rst = ($urandom % 100) == 0;
      drive(($urandom % 4) != 0, $urandom, $urandom, ($urandom % 3) == 0, ($urandom % 16) == 0);
      if (($urandom % 20) == 0) INT = ~INT;
      INT_INST = $urandom;
      cycle("rnd");
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
